// File: rtl/snes_pad_reader.sv
// -----------------------------------------------------------------------------
// snes_pad_reader
//
// Polls an SNES gamepad over its latch / clock / serial-data interface at a
// fixed rate, decodes the 12 button bits and produces the 4-bit button code
// consumed by the Tetris grid controller (0 = none, 1..12 = serial bit + 1,
// lowest bit index wins when several buttons are held).
//
// Each poll: latch pulse (2H), gap (H), 16 bits shifted with H-cycle low and
// high phases, then one decode cycle. Outputs update 35H+1 cycles after the
// poll starts, together with poll_done. H = HALF_PERIOD.
//
// Optional build macro:
//   PAD_AUTOREPEAT_EN  controller_out becomes a one-cycle pulse (coincident
//                      with poll_done) on a new code, and again after
//                      REPEAT_DELAY polls and then every REPEAT_RATE polls
//                      while the same code is held. Undefined: controller_out
//                      is a level that holds the last decoded code.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high
//   pad_data        serial data from pad, active-low (0 = pressed)
//   pad_latch       latch pulse to pad, active-high, registered
//   pad_clk         pad shift clock, idles high, registered
//   controller_out  button code to the grid controller
//   buttons         pressed vector, active-high, bit i = serial bit i
//   poll_done       one-cycle pulse when buttons/controller_out update
// -----------------------------------------------------------------------------
module snes_pad_reader #(
    parameter int HALF_PERIOD  = 300,
    parameter int POLL_PERIOD  = 833333,
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [3:0]  controller_out,
    output logic [11:0] buttons,
    output logic        poll_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LATCH  = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] CLK_LO = 3'd3;
    localparam logic [2:0] CLK_HI = 3'd4;
    localparam logic [2:0] DECODE = 3'd5;

    localparam int TMR_W  = $clog2(2 * HALF_PERIOD);
    localparam int POLL_W = $clog2(POLL_PERIOD);

    // Phase timers count down to zero, so load with length - 1.
    localparam logic [TMR_W-1:0]  LATCH_LOAD = TMR_W'(2 * HALF_PERIOD - 1);
    localparam logic [TMR_W-1:0]  HALF_LOAD  = TMR_W'(HALF_PERIOD - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

    // A poll must finish before the next one starts, otherwise the start
    // condition (counter == 0) would be missed while the FSM is busy.
    if (HALF_PERIOD < 1 || POLL_PERIOD < 35 * HALF_PERIOD + 2 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("snes_pad_reader: illegal parameter combination");
    end

    logic [2:0]        state_reg;
    logic [POLL_W-1:0] poll_cnt_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic [4:0]        bit_idx_reg;
    logic [11:0]       shift_reg;
    logic              pad_latch_reg;
    logic              pad_clk_reg;
    logic [11:0]       buttons_reg;
    logic              poll_done_reg;

    // ------------------------------------------------------------------
    // Poll sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            poll_cnt_reg  <= '0;
            timer_reg     <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            pad_latch_reg <= 1'b0;
            pad_clk_reg   <= 1'b1;
            buttons_reg   <= '0;
            poll_done_reg <= 1'b0;
        end else begin
            poll_done_reg <= 1'b0;

            if (poll_cnt_reg == POLL_LAST) begin
                poll_cnt_reg <= '0;
            end else begin
                poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    bit_idx_reg <= '0;
                    if (poll_cnt_reg == '0) begin
                        state_reg     <= LATCH;
                        timer_reg     <= LATCH_LOAD;
                        pad_latch_reg <= 1'b1;
                    end
                end

                LATCH: begin
                    if (timer_reg == '0) begin
                        state_reg     <= GAP;
                        timer_reg     <= HALF_LOAD;
                        pad_latch_reg <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg - TMR_W'(1);
                    end
                end

                // Leaving GAP or CLK_HI samples the bit the pad is currently
                // presenting and starts the next low phase. Once all 16
                // rising edges have been issued, go decode instead.
                GAP, CLK_HI: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - TMR_W'(1);
                    end else if (bit_idx_reg == 5'd16) begin
                        state_reg <= DECODE;
                    end else begin
                        // Bit 0 enters at the top and ends up at [0] after
                        // 12 shifts; bits 12..15 are clocked out but ignored.
                        if (bit_idx_reg < 5'd12) begin
                            shift_reg <= {~pad_data, shift_reg[11:1]};
                        end
                        pad_clk_reg <= 1'b0;
                        timer_reg   <= HALF_LOAD;
                        state_reg   <= CLK_LO;
                    end
                end

                CLK_LO: begin
                    if (timer_reg == '0) begin
                        state_reg   <= CLK_HI;
                        timer_reg   <= HALF_LOAD;
                        pad_clk_reg <= 1'b1;
                        bit_idx_reg <= bit_idx_reg + 5'd1;
                    end else begin
                        timer_reg <= timer_reg - TMR_W'(1);
                    end
                end

                DECODE: begin
                    state_reg     <= IDLE;
                    buttons_reg   <= shift_reg;
                    poll_done_reg <= 1'b1;
                end

                default: begin
                    state_reg     <= IDLE;
                    pad_latch_reg <= 1'b0;
                    pad_clk_reg   <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Priority encoder: lowest pressed bit i gives code i + 1
    // ------------------------------------------------------------------
    logic [11:0] first_set;
    logic [3:0]  decoded_code;

    for (genvar gi = 0; gi < 12; gi++) begin : g_prio
        if (gi == 0) begin : g_lsb
            assign first_set[gi] = shift_reg[gi];
        end else begin : g_upper
            assign first_set[gi] = shift_reg[gi] & ~(|shift_reg[gi-1:0]);
        end
    end

    // first_set is one-hot or zero, so OR-ing the candidate codes is exact.
    always_comb begin
        decoded_code = '0;
        for (int i = 0; i < 12; i++) begin
            if (first_set[i]) begin
                decoded_code = decoded_code | 4'(i + 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // controller_out: level or auto-repeat pulse
    // ------------------------------------------------------------------
`ifdef PAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [3:0]       prev_code_reg;
    logic [REP_W-1:0] rep_cnt_reg;
    logic [3:0]       pulse_reg;

    // rep_cnt_reg counts down the polls remaining until the next repeat;
    // it is reloaded with REPEAT_DELAY on a fresh press and REPEAT_RATE
    // after every repeat.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_code_reg <= '0;
            rep_cnt_reg   <= '0;
            pulse_reg     <= '0;
        end else begin
            pulse_reg <= '0;
            if (state_reg == DECODE) begin
                prev_code_reg <= decoded_code;
                if (decoded_code == '0) begin
                    rep_cnt_reg <= REP_W'(REPEAT_DELAY);
                end else if (decoded_code != prev_code_reg) begin
                    pulse_reg   <= decoded_code;
                    rep_cnt_reg <= REP_W'(REPEAT_DELAY);
                end else if (rep_cnt_reg == REP_W'(1)) begin
                    pulse_reg   <= decoded_code;
                    rep_cnt_reg <= REP_W'(REPEAT_RATE);
                end else begin
                    rep_cnt_reg <= rep_cnt_reg - REP_W'(1);
                end
            end
        end
    end

    assign controller_out = pulse_reg;
`else
    logic [3:0] code_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            code_reg <= '0;
        end else if (state_reg == DECODE) begin
            code_reg <= decoded_code;
        end
    end

    assign controller_out = code_reg;
`endif

    assign pad_latch = pad_latch_reg;
    assign pad_clk   = pad_clk_reg;
    assign buttons   = buttons_reg;
    assign poll_done = poll_done_reg;

endmodule

// File: tb/tb_snes_pad_reader.sv
// -----------------------------------------------------------------------------
// tb_snes_pad_reader
//
// Bench for snes_pad_reader with H=2, POLL_PERIOD=100. A behavioural SNES pad
// snapshots its button vector on the pad_latch rising edge, presents bit 0,
// and advances one bit per pad_clk rising edge. Each snapshot pushes the
// expected decode into a queue; a monitor pops it when poll_done appears and
// also checks output hold, latch width, pad_clk edge count and decode timing.
// Honours PAD_AUTOREPEAT_EN (REPEAT_DELAY=2, REPEAT_RATE=1) in its model.
// -----------------------------------------------------------------------------
module tb_snes_pad_reader;

    localparam int H       = 2;
    localparam int P       = 100;
    localparam int RD      = 2;
    localparam int RR      = 1;
    localparam int DONE_AT = 35 * H + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [3:0]  controller_out;
    logic [11:0] buttons;
    logic        poll_done;

    always #5 clk = ~clk;

    snes_pad_reader #(
        .HALF_PERIOD  (H),
        .POLL_PERIOD  (P),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pad_data       (pad_data),
        .pad_latch      (pad_latch),
        .pad_clk        (pad_clk),
        .controller_out (controller_out),
        .buttons        (buttons),
        .poll_done      (poll_done)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [11:0] b;
        logic [3:0]  c;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] pad_buttons = '0;   // pressed = 1, as the pad will see it
    logic [15:0] pad_snap    = '0;
    logic [4:0]  pad_idx     = '0;
`ifdef PAD_AUTOREPEAT_EN
    logic [3:0]  ar_code = '0;
    int          ar_n    = 0;
`endif

    assign pad_data = (pad_idx < 5'd16) ? ~pad_snap[pad_idx[3:0]] : 1'b1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] lowest_code(input logic [11:0] b);
        for (int i = 0; i < 12; i++) begin
            if (b[i]) return 4'(i + 1);
        end
        return 4'd0;
    endfunction

    // Expected output of a poll, given the buttons held when it was latched.
    function automatic exp_t model_expect(input logic [11:0] pressed);
        exp_t       e;
        logic [3:0] code;
        code = lowest_code(pressed);
        e.b  = pressed;
`ifdef PAD_AUTOREPEAT_EN
        // ar_n = polls since the first emission of the held code.
        if (code == 4'd0) begin
            ar_code = 4'd0;
            e.c     = 4'd0;
        end else if (code != ar_code) begin
            ar_code = code;
            ar_n    = 0;
            e.c     = code;
        end else begin
            ar_n++;
            e.c = (ar_n >= RD && (ar_n - RD) % RR == 0) ? code : 4'd0;
        end
`else
        e.c = code;
`endif
        return e;
    endfunction

    // Pad model + scoreboard producer.
    initial begin : pad_model
        forever begin
            @(posedge pad_clk or posedge pad_latch or posedge reset);
            if (reset) begin
                exp_q.delete();
`ifdef PAD_AUTOREPEAT_EN
                ar_code = 4'd0;
                ar_n    = 0;
`endif
            end else if (pad_latch) begin
                pad_idx  = '0;
                pad_snap = pad_buttons;
                exp_q.push_back(model_expect(pad_buttons[11:0]));
            end else if (pad_idx < 5'd16) begin
                pad_idx = pad_idx + 5'd1;
            end
        end
    end

    // Monitor / scoreboard consumer, sampling on the falling clock edge.
    int          cyc = 0;
    int          latch_start = 0;
    int          latch_len = 0;
    int          fall_cnt = 0;
    int          poll_no = 0;
    logic        prev_latch = 1'b0;
    logic        prev_pclk = 1'b1;
    logic [11:0] last_b = '0;
    logic [3:0]  last_c = '0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                last_b    = '0;
                last_c    = '0;
                latch_len = 0;
                fall_cnt  = 0;
            end else begin
                if (pad_latch && !prev_latch) begin
                    latch_start = cyc;
                    latch_len   = 0;
                    fall_cnt    = 0;
                end
                if (pad_latch) latch_len++;
                if (!pad_latch && prev_latch) check("latch_width", latch_len, 2 * H);
                if (!pad_clk && prev_pclk) fall_cnt++;

                if (poll_done) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_poll_done: got poll_done=1, expected no pending poll (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        poll_no++;
                        $display("[TB] poll %0d: buttons=%03h (exp %03h) controller_out=%0d (exp %0d)",
                                 poll_no, buttons, e.b, controller_out, e.c);
                        check("buttons", int'(buttons), int'(e.b));
                        check("controller_out", int'(controller_out), int'(e.c));
                        check("done_cycle", cyc - latch_start, DONE_AT);
                        check("pad_clk_falls", fall_cnt, 16);
                        last_b = e.b;
`ifdef PAD_AUTOREPEAT_EN
                        last_c = 4'd0;
`else
                        last_c = e.c;
`endif
                    end
                end else begin
                    check("buttons_hold", int'(buttons), int'(last_b));
                    check("controller_out_hold", int'(controller_out), int'(last_c));
                end
            end
            prev_latch = pad_latch;
            prev_pclk  = pad_clk;
        end
    end

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (poll_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("poll_done_timeout", int'(ok), 1);
    endtask

    // Value takes effect at the next latch; waits for that poll to finish.
    task automatic run_poll(input logic [15:0] val);
        pad_buttons = val;
        wait_done();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pad_clk"}, int'(pad_clk), 1);
        check({tag, "_pad_latch"}, int'(pad_latch), 0);
        check({tag, "_controller_out"}, int'(controller_out), 0);
        check({tag, "_buttons"}, int'(buttons), 0);
        check({tag, "_poll_done"}, int'(poll_done), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] directed [12] = '{
        16'h0080,   // RIGHT only
        16'h00C0,   // LEFT + RIGHT
        16'h0009,   // START + B
        16'h0000,   // none
        16'hF000,   // only the unused bits 12..15
        16'hFFFF,   // everything
        16'h0000,
        16'h0008,   // START held for five polls
        16'h0008,
        16'h0008,
        16'h0008,
        16'h0008
    };

    initial begin : stimulus
        logic [15:0] val;
        logic [15:0] prev_val;
        bit          seen;

        // Reset held three cycles, then first poll starts immediately.
        pad_buttons = 16'h0080;
        reset       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_reset_values("reset");
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("latch_after_reset", int'(pad_latch), (k < 4) ? 1 : 0);
        end
        wait_done();

        foreach (directed[i]) run_poll(directed[i]);
        run_poll(16'h0000);   // release

        prev_val = 16'h0000;
        for (int n = 0; n < 24; n++) begin
            val = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 1) == 1) val = val & (16'hFFFF << $urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) val = prev_val;
            run_poll(val);
            prev_val = val;
        end

        // Reset in the middle of a poll (cycle 30 after latch rise).
        pad_buttons = 16'h0004;
        seen = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(posedge clk); #1;
            if (pad_latch) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_reset_latch_seen", int'(seen), 1);
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("mid_reset");
        pad_buttons = 16'h0040;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("latch_after_mid_reset", int'(pad_latch), 1);
        wait_done();

        run_poll(16'h0100);
        run_poll(16'h0100);
        run_poll(16'h0800);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
